mil1553_bus_mux: RTL and testbench
==================================

// Module: mil1553_bus_mux
// PURPOSE
//  Sits between uart_1553_core and the pmod pins, fanning one 1553 PHY interface out to
//  NUM_BUSES redundant buses (A/B/...). Selects the active bus only between transmissions.
//  Enforces a fail-safe transmitter timeout that latches a fault and kills all bus drivers.
//  Synchronises the asynchronous receive pins into aclk.
// PARAMETERS
//  NUM_BUSES      2        number of physical 1553 buses, >=2
//  CLOCK_SPEED    2000000  aclk frequency in Hz
//  TX_TIMEOUT_US  800      max continuous en_tx time in microseconds
//  localparam TIMEOUT_CYC = CLOCK_SPEED*TX_TIMEOUT_US/1000000 (1600 at defaults)
//  localparam SELW = $clog2(NUM_BUSES)
// PORTS
//  aclk        in   1          system clock
//  arst        in   1          synchronous reset, active high
//  bus_sel     in   SELW       requested bus index
//  fault_clr   in   1          clears a latched tx fault
//  core_tx0    in   1          tx0 from core
//  core_tx1    in   1          tx1 from core
//  core_en_tx  in   1          transmit enable from core
//  core_rx0    out  1          rx0 to core, from active bus
//  core_rx1    out  1          rx1 to core, from active bus
//  bus_rx0     in   NUM_BUSES  rx0 pins, asynchronous
//  bus_rx1     in   NUM_BUSES  rx1 pins, asynchronous
//  bus_tx0     out  NUM_BUSES  tx0 pins
//  bus_tx1     out  NUM_BUSES  tx1 pins
//  bus_en_tx   out  NUM_BUSES  transmitter enable pins
//  active_bus  out  SELW       bus currently routed
//  busy        out  1          1 in TX state
//  tx_fault    out  1          1 in FAULT state
// BEHAVIOUR
//  - Reset: state=IDLE, active_bus=0, timer=0, sync flops=0.
//    All outputs are 0 after reset, including busy and tx_fault.
//  - FSM states:
//    - IDLE: each cycle, active_bus<=bus_sel if bus_sel<NUM_BUSES, else hold.
//      core_en_tx=1 -> TX with timer=0. active_bus is frozen from this edge on.
//    - TX: timer+1 each cycle. core_en_tx=0 -> IDLE with timer=0.
//      core_en_tx=1 and timer==TIMEOUT_CYC-1 -> FAULT.
//      If both conditions hit on the same edge, en_tx=0 wins and the FSM goes to IDLE.
//    - FAULT: all bus_* tx outputs are 0.
//      fault_clr=1 and core_en_tx=0 -> IDLE. fault_clr is ignored while core_en_tx=1.
//  - TX path is registered, 1 cycle latency.
//    In IDLE or TX: bus_tx0/tx1/en_tx[active_bus] <= core_tx0/tx1/en_tx; all other indices <= 0.
//    The cycle entering FAULT drives en_tx=0 on the next edge. Max en_tx high time = TIMEOUT_CYC cycles.
//  - RX path: per-bit 2-flop synchroniser on every bus_rx0/1 line, then a registered mux on active_bus.
//    Latency from pin to core_rx0/1 is 3 cycles. RX stays routed in every state, including FAULT.
//  - bus_sel changes during TX or FAULT have no effect until IDLE; the last in-range value is then taken.
//  - Timer width is $clog2(TIMEOUT_CYC+1) and never wraps; it is cleared on every IDLE entry.
//  - busy=1 only in TX; tx_fault=1 only in FAULT; active_bus is registered.
//  - arst mid-transmission: all en_tx drop to 0 on the reset edge, and the FSM returns to IDLE.
// TESTING
//  (NUM_BUSES=2, CLOCK_SPEED=2000000, TX_TIMEOUT_US=10 -> TIMEOUT_CYC=20)
//  1. arst 2 cycles, bus_sel=1, en_tx=1 pulse of 5 cycles
//     -> active_bus=1, bus_en_tx=2'b10 for exactly 5 cycles (1-cycle delay), bus 0 tx stays 0.
//  2. bus_sel 0->1 while busy=1
//     -> active_bus stays 0 until en_tx falls, and becomes 1 one cycle after IDLE.
//  3. en_tx held high 30 cycles
//     -> bus_en_tx high 20 cycles then 0, tx_fault=1.
//     fault_clr while en_tx=1 -> no change; en_tx=0 plus fault_clr -> tx_fault=0 next cycle.
//  4. en_tx falls on the cycle timer==19 -> IDLE, tx_fault stays 0.
//  5. Toggle bus_rx0[1] with active_bus=1 -> core_rx0 follows 3 cycles later.
//     Toggling bus_rx0[0] has no effect on core_rx0.
//  6. bus_sel=2 (out of range) in IDLE -> active_bus holds.
//     arst during TX -> all bus_en_tx=0 and busy=0 after the reset edge.

Source files
------------

// File: rtl/mil1553_bus_mux_if.sv
// mil1553_bus_mux_if
//  Groups the 1553 PHY signals on both sides of the bus mux.
//  Core side: core_tx0/core_tx1/core_en_tx toward the buses, core_rx0/core_rx1 back to the core.
//  Bus side : per-bus bus_rx0/bus_rx1 (asynchronous pins), bus_tx0/bus_tx1/bus_en_tx (pin drivers).
//  slave  : view used by the mux itself.
//  master : view used by whoever drives the core inputs and the receive pins.
interface mil1553_bus_mux_if #(
  parameter int NUM_BUSES = 2
);
  logic                 core_tx0;
  logic                 core_tx1;
  logic                 core_en_tx;
  logic                 core_rx0;
  logic                 core_rx1;
  logic [NUM_BUSES-1:0] bus_rx0;
  logic [NUM_BUSES-1:0] bus_rx1;
  logic [NUM_BUSES-1:0] bus_tx0;
  logic [NUM_BUSES-1:0] bus_tx1;
  logic [NUM_BUSES-1:0] bus_en_tx;

  modport slave (
    input  core_tx0, core_tx1, core_en_tx, bus_rx0, bus_rx1,
    output core_rx0, core_rx1, bus_tx0, bus_tx1, bus_en_tx
  );

  modport master (
    output core_tx0, core_tx1, core_en_tx, bus_rx0, bus_rx1,
    input  core_rx0, core_rx1, bus_tx0, bus_tx1, bus_en_tx
  );
endinterface

// File: rtl/mil1553_bus_mux.sv
// mil1553_bus_mux
//  Fans one 1553 PHY interface out to NUM_BUSES redundant buses. The active bus is only
//  re-selected between transmissions. A transmitter timeout latches a fault that kills
//  every bus driver until cleared. Receive pins are synchronised into aclk.
// Ports
//  aclk, arst  : clock and synchronous active-high reset
//  bus_sel     : requested bus index (out-of-range values are ignored)
//  fault_clr   : clears a latched tx fault once core_en_tx is low
//  phy         : core-side and bus-side PHY signals (slave modport)
//  active_bus  : bus currently routed
//  busy        : high while transmitting
//  tx_fault    : high while the timeout fault is latched
module mil1553_bus_mux #(
  parameter int NUM_BUSES     = 2,
  parameter int CLOCK_SPEED   = 2000000,
  parameter int TX_TIMEOUT_US = 800
) (
  input  logic                         aclk,
  input  logic                         arst,
  input  logic [$clog2(NUM_BUSES)-1:0] bus_sel,
  input  logic                         fault_clr,
  mil1553_bus_mux_if.slave             phy,
  output logic [$clog2(NUM_BUSES)-1:0] active_bus,
  output logic                         busy,
  output logic                         tx_fault
);

  localparam int SELW        = $clog2(NUM_BUSES);
  localparam int TIMEOUT_CYC = int'((64'(CLOCK_SPEED) * 64'(TX_TIMEOUT_US)) / 64'd1000000);
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TX    = 2'd1,
    FAULT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [SELW-1:0]      active_bus_q, active_bus_d;
  logic [NUM_BUSES-1:0] bus_tx0_q, bus_tx0_d;
  logic [NUM_BUSES-1:0] bus_tx1_q, bus_tx1_d;
  logic [NUM_BUSES-1:0] bus_en_tx_q, bus_en_tx_d;
  logic [NUM_BUSES-1:0] rx0_s1_q, rx0_s1_d, rx0_s2_q, rx0_s2_d;
  logic [NUM_BUSES-1:0] rx1_s1_q, rx1_s1_d, rx1_s2_q, rx1_s2_d;
  logic                 core_rx0_q, core_rx0_d;
  logic                 core_rx1_q, core_rx1_d;
  logic                 sel_ok;
  logic                 tx_route;

  // Bus selection is checked by matching against every legal index, so a
  // non-power-of-two bus count simply ignores the unused codes.
  always_comb begin
    sel_ok = 1'b0;
    for (int i = 0; i < NUM_BUSES; i++) begin
      if (bus_sel == SELW'(i)) sel_ok = 1'b1;
    end
  end

  // The timer saturates rather than wrapping; it is only ever compared
  // against TIMEOUT_CYC-1, reached on the last permitted TX cycle.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    active_bus_d = active_bus_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (sel_ok) active_bus_d = bus_sel;
        if (phy.core_en_tx) state_d = TX;
      end
      TX: begin
        if (!phy.core_en_tx) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          if (timer_q == TW'(TIMEOUT_CYC - 1)) state_d = FAULT;
          if (timer_q != TW'(TIMEOUT_CYC)) timer_d = timer_q + TW'(1);
        end
      end
      FAULT: begin
        if (fault_clr && !phy.core_en_tx) begin
          state_d = IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Drivers are routed to the bus being latched on this edge, so the first
  // cycle of a transmission lands on the same bus as the rest of it. Gating on
  // state_d drops en_tx on the very edge that enters FAULT, which caps the
  // enable pulse at TIMEOUT_CYC cycles.
  always_comb begin
    tx_route    = (state_q != FAULT) && (state_d != FAULT);
    bus_tx0_d   = '0;
    bus_tx1_d   = '0;
    bus_en_tx_d = '0;
    for (int i = 0; i < NUM_BUSES; i++) begin
      if (tx_route && (active_bus_d == SELW'(i))) begin
        bus_tx0_d[i]   = phy.core_tx0;
        bus_tx1_d[i]   = phy.core_tx1;
        bus_en_tx_d[i] = phy.core_en_tx;
      end
    end
  end

  // Two-flop synchroniser per pin, then a registered mux on the routed bus.
  always_comb begin
    rx0_s1_d   = phy.bus_rx0;
    rx1_s1_d   = phy.bus_rx1;
    rx0_s2_d   = rx0_s1_q;
    rx1_s2_d   = rx1_s1_q;
    core_rx0_d = 1'b0;
    core_rx1_d = 1'b0;
    for (int i = 0; i < NUM_BUSES; i++) begin
      if (active_bus_q == SELW'(i)) begin
        core_rx0_d = rx0_s2_q[i];
        core_rx1_d = rx1_s2_q[i];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      active_bus_q <= '0;
      bus_tx0_q    <= '0;
      bus_tx1_q    <= '0;
      bus_en_tx_q  <= '0;
      rx0_s1_q     <= '0;
      rx0_s2_q     <= '0;
      rx1_s1_q     <= '0;
      rx1_s2_q     <= '0;
      core_rx0_q   <= 1'b0;
      core_rx1_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      active_bus_q <= active_bus_d;
      bus_tx0_q    <= bus_tx0_d;
      bus_tx1_q    <= bus_tx1_d;
      bus_en_tx_q  <= bus_en_tx_d;
      rx0_s1_q     <= rx0_s1_d;
      rx0_s2_q     <= rx0_s2_d;
      rx1_s1_q     <= rx1_s1_d;
      rx1_s2_q     <= rx1_s2_d;
      core_rx0_q   <= core_rx0_d;
      core_rx1_q   <= core_rx1_d;
    end
  end

  assign phy.bus_tx0   = bus_tx0_q;
  assign phy.bus_tx1   = bus_tx1_q;
  assign phy.bus_en_tx = bus_en_tx_q;
  assign phy.core_rx0  = core_rx0_q;
  assign phy.core_rx1  = core_rx1_q;
  assign active_bus    = active_bus_q;
  assign busy          = (state_q == TX);
  assign tx_fault      = (state_q == FAULT);

endmodule

// File: tb/tb_mil1553_bus_mux.sv
// tb_mil1553_bus_mux
//  Randomised and directed stimulus for mil1553_bus_mux (2 buses, 20-cycle timeout).
//  Each applied input vector is fed to a behavioural model whose expected outputs are
//  queued; a monitor pops one entry per clock edge and compares it with the DUT.
//  A second 3-bus instance covers out-of-range bus selection.
module tb_mil1553_bus_mux;

  localparam int NB   = 2;
  localparam int TOUT = 20;

  typedef struct {
    logic       rst;
    logic       sel;
    logic       clr;
    logic       tx0;
    logic       tx1;
    logic       en;
    logic [1:0] rx0;
    logic [1:0] rx1;
  } stim_t;

  typedef struct {
    logic [1:0] en_tx;
    logic [1:0] tx0;
    logic [1:0] tx1;
    logic       rx0;
    logic       rx1;
    logic       act;
    logic       busy;
    logic       fault;
  } exp_t;

  logic       aclk = 1'b0;
  logic       arst;
  logic [0:0] bus_sel;
  logic       fault_clr;
  logic [0:0] active_bus;
  logic       busy;
  logic       tx_fault;

  logic       arst3;
  logic [1:0] bus_sel3;
  logic       fault_clr3;
  logic [1:0] active_bus3;
  logic       busy3;
  logic       tx_fault3;

  int tests_run    = 0;
  int tests_failed = 0;

  exp_t sb[$];

  // Model state: mode 0 idle, 1 transmitting, 2 faulted; burst counts cycles
  // the enable has been driven in the current transmission.
  int         m_mode;
  int         m_bus;
  int         m_burst;
  logic [1:0] m_p1_0, m_p2_0, m_p1_1, m_p2_1;

  mil1553_bus_mux_if #(.NUM_BUSES(NB)) phy ();
  mil1553_bus_mux_if #(.NUM_BUSES(3))  phy3 ();

  mil1553_bus_mux #(
    .NUM_BUSES(NB), .CLOCK_SPEED(2000000), .TX_TIMEOUT_US(10)
  ) dut (
    .aclk(aclk), .arst(arst), .bus_sel(bus_sel), .fault_clr(fault_clr),
    .phy(phy.slave), .active_bus(active_bus), .busy(busy), .tx_fault(tx_fault)
  );

  mil1553_bus_mux #(
    .NUM_BUSES(3), .CLOCK_SPEED(2000000), .TX_TIMEOUT_US(10)
  ) dut3 (
    .aclk(aclk), .arst(arst3), .bus_sel(bus_sel3), .fault_clr(fault_clr3),
    .phy(phy3.slave), .active_bus(active_bus3), .busy(busy3), .tx_fault(tx_fault3)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of the specified behaviour, written as rules on modes and counts.
  task automatic model_step(input stim_t s, output exp_t e);
    int  old_bus;
    logic route;
    e = '{default: '0};
    if (s.rst) begin
      m_mode = 0; m_bus = 0; m_burst = 0;
      m_p1_0 = '0; m_p2_0 = '0; m_p1_1 = '0; m_p2_1 = '0;
      return;
    end
    old_bus = m_bus;
    e.rx0 = m_p2_0[old_bus];
    e.rx1 = m_p2_1[old_bus];
    m_p2_0 = m_p1_0; m_p1_0 = s.rx0;
    m_p2_1 = m_p1_1; m_p1_1 = s.rx1;
    route = 1'b0;
    case (m_mode)
      0: begin
        m_bus = int'(s.sel);
        route = 1'b1;
        if (s.en) begin m_mode = 1; m_burst = 1; end
      end
      1: begin
        if (!s.en) begin m_mode = 0; route = 1'b1; end
        else if (m_burst == TOUT) m_mode = 2;
        else begin m_burst++; route = 1'b1; end
      end
      default: begin
        if (s.clr && !s.en) m_mode = 0;
      end
    endcase
    if (route) begin
      e.en_tx[m_bus] = s.en;
      e.tx0[m_bus]   = s.tx0;
      e.tx1[m_bus]   = s.tx1;
    end
    e.act   = 1'(m_bus);
    e.busy  = (m_mode == 1);
    e.fault = (m_mode == 2);
  endtask

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(negedge aclk);
    arst           = s.rst;
    bus_sel        = s.sel;
    fault_clr      = s.clr;
    phy.core_tx0   = s.tx0;
    phy.core_tx1   = s.tx1;
    phy.core_en_tx = s.en;
    phy.bus_rx0    = s.rx0;
    phy.bus_rx1    = s.rx1;
    model_step(s, e);
    sb.push_back(e);
  endtask

  task automatic step_sample(input stim_t s);
    applyStimulus(s);
    @(posedge aclk);
    #2;
  endtask

  // Monitor: every edge that has a queued expectation is compared field by field.
  initial begin
    exp_t e;
    forever begin
      @(posedge aclk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("sb_bus_en_tx",  32'(phy.bus_en_tx), 32'(e.en_tx));
        checkOutput("sb_bus_tx0",    32'(phy.bus_tx0),   32'(e.tx0));
        checkOutput("sb_bus_tx1",    32'(phy.bus_tx1),   32'(e.tx1));
        checkOutput("sb_core_rx0",   32'(phy.core_rx0),  32'(e.rx0));
        checkOutput("sb_core_rx1",   32'(phy.core_rx1),  32'(e.rx1));
        checkOutput("sb_active_bus", 32'(active_bus),    32'(e.act));
        checkOutput("sb_busy",       32'(busy),          32'(e.busy));
        checkOutput("sb_tx_fault",   32'(tx_fault),      32'(e.fault));
      end
    end
  end

  initial begin
    stim_t s;
    int    cnt, cnt0, run;
    logic  en_phase;

    arst = 1'b1; bus_sel = '0; fault_clr = 1'b0;
    phy.core_tx0 = 1'b0; phy.core_tx1 = 1'b0; phy.core_en_tx = 1'b0;
    phy.bus_rx0 = '0; phy.bus_rx1 = '0;
    arst3 = 1'b1; bus_sel3 = '0; fault_clr3 = 1'b0;
    phy3.core_tx0 = 1'b0; phy3.core_tx1 = 1'b0; phy3.core_en_tx = 1'b0;
    phy3.bus_rx0 = '0; phy3.bus_rx1 = '0;

    s = '{default: '0};
    s.rst = 1'b1;
    applyStimulus(s);
    step_sample(s);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_fault", 32'(tx_fault), 0);
    checkOutput("reset_en_tx", 32'(phy.bus_en_tx), 0);
    checkOutput("reset_active", 32'(active_bus), 0);
    s.rst = 1'b0;

    // Bus 1 selected, 5-cycle enable pulse.
    s.sel = 1'b1;
    step_sample(s);
    cnt = 0; cnt0 = 0;
    for (int i = 0; i < 9; i++) begin
      s.en  = (i < 5);
      s.tx0 = 1'($urandom);
      s.tx1 = 1'($urandom);
      step_sample(s);
      if (phy.bus_en_tx == 2'b10) cnt++;
      if (phy.bus_en_tx[0] | phy.bus_tx0[0] | phy.bus_tx1[0]) cnt0++;
    end
    checkOutput("t1_en_cycles", 32'(cnt), 5);
    checkOutput("t1_bus0_quiet", 32'(cnt0), 0);
    checkOutput("t1_active", 32'(active_bus), 1);

    // Selection change while busy is deferred until after the transmission.
    s.sel = 1'b0; s.tx0 = 1'b0; s.tx1 = 1'b0;
    step_sample(s);
    step_sample(s);
    s.en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) s.sel = 1'b1;
      step_sample(s);
      checkOutput("t2_active_frozen", 32'(active_bus), 0);
    end
    s.en = 1'b0;
    step_sample(s);
    checkOutput("t2_active_at_idle", 32'(active_bus), 0);
    checkOutput("t2_busy_low", 32'(busy), 0);
    step_sample(s);
    checkOutput("t2_active_updated", 32'(active_bus), 1);

    // Timeout: 30 cycles of enable give exactly TOUT driven cycles.
    cnt = 0;
    s.en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step_sample(s);
      if (phy.bus_en_tx != 2'b00) cnt++;
    end
    checkOutput("t3_en_cycles", 32'(cnt), TOUT);
    checkOutput("t3_fault", 32'(tx_fault), 1);
    s.clr = 1'b1;
    step_sample(s);
    step_sample(s);
    checkOutput("t3_clr_ignored", 32'(tx_fault), 1);
    checkOutput("t3_en_killed", 32'(phy.bus_en_tx), 0);
    s.en = 1'b0;
    step_sample(s);
    checkOutput("t3_fault_cleared", 32'(tx_fault), 0);
    s.clr = 1'b0;

    // Enable falling on the last permitted cycle is a normal end of transmission.
    cnt = 0;
    for (int i = 0; i < 23; i++) begin
      s.en = (i < TOUT);
      step_sample(s);
      if (phy.bus_en_tx != 2'b00) cnt++;
    end
    checkOutput("t4_en_cycles", 32'(cnt), TOUT);
    checkOutput("t4_no_fault", 32'(tx_fault), 0);
    checkOutput("t4_idle", 32'(busy), 0);

    // Receive path: 3-cycle latency on the routed bus, other bus ignored.
    s.rx0 = 2'b00;
    for (int i = 0; i < 3; i++) step_sample(s);
    s.rx0 = 2'b10;
    step_sample(s);
    checkOutput("t5_rx_lat1", 32'(phy.core_rx0), 0);
    step_sample(s);
    checkOutput("t5_rx_lat2", 32'(phy.core_rx0), 0);
    step_sample(s);
    checkOutput("t5_rx_lat3", 32'(phy.core_rx0), 1);
    for (int i = 0; i < 4; i++) begin
      s.rx0[0] = ~s.rx0[0];
      step_sample(s);
      checkOutput("t5_rx_other_bus", 32'(phy.core_rx0), 1);
    end

    // Reset in the middle of a transmission.
    s.en = 1'b1;
    for (int i = 0; i < 3; i++) step_sample(s);
    s.rst = 1'b1;
    step_sample(s);
    checkOutput("t6_rst_busy", 32'(busy), 0);
    checkOutput("t6_rst_en_tx", 32'(phy.bus_en_tx), 0);
    s.rst = 1'b0; s.en = 1'b0;
    step_sample(s);

    // Randomised traffic: bursts long enough to hit the timeout, random clears,
    // selections, pin activity and the occasional reset.
    run = 0; en_phase = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (run == 0) begin
        en_phase = ~en_phase;
        run = en_phase ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 6));
      end
      run--;
      s.en  = en_phase;
      s.rst = ($urandom_range(0, 299) == 0);
      s.sel = 1'($urandom);
      s.clr = ($urandom_range(0, 3) == 0);
      s.tx0 = 1'($urandom);
      s.tx1 = 1'($urandom);
      s.rx0 = 2'($urandom);
      s.rx1 = 2'($urandom);
      applyStimulus(s);
    end
    s = '{default: '0};
    applyStimulus(s);
    @(posedge aclk);
    #2;
    checkOutput("sb_drained", 32'(sb.size()), 0);

    // Three-bus instance: unused selection code must not move the active bus.
    @(negedge aclk);
    arst3 = 1'b1;
    @(negedge aclk);
    arst3 = 1'b0; bus_sel3 = 2'd2;
    @(posedge aclk);
    #2;
    checkOutput("nb3_sel2", 32'(active_bus3), 2);
    @(negedge aclk);
    bus_sel3 = 2'd3;
    @(posedge aclk);
    #2;
    checkOutput("nb3_sel3_hold", 32'(active_bus3), 2);
    @(negedge aclk);
    @(posedge aclk);
    #2;
    checkOutput("nb3_sel3_hold2", 32'(active_bus3), 2);
    @(negedge aclk);
    bus_sel3 = 2'd1;
    @(posedge aclk);
    #2;
    checkOutput("nb3_sel1", 32'(active_bus3), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
